// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one fixed_point_adder among N_REQ requesters
module fixed_point_adder (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum,
   output logic        done
);
   logic [16:0] s1;
   logic        v1;
   // two-stage adder: widen and add on enable, publish halved sum with done one edge later
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= '0;
         v1   <= 1'b0;
         sum  <= '0;
         done <= 1'b0;
      end else begin
         v1   <= enable;
         done <= v1;
         if (enable) s1 <= {a[15], a} + {b[15], b};
         if (v1) sum <= s1[16:1];
      end
   end
endmodule

module adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*16-1:0] a_in,
   input  logic [N_REQ*16-1:0] b_in,
   output logic [N_REQ-1:0]    ack,
   output logic [15:0]         result,
   output logic [ID_W-1:0]     result_id,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t            state, state_n;
   logic [ID_W-1:0]   ptr, id, win, idx;
   logic [15:0]       a_q, b_q, sum;
   logic [N_REQ-1:0]  mreq;
   logic              found, grant, enable, finish, done;
   assign mreq = req & ~ack;
   fixed_point_adder u_add (
      .clk    (clk),
      .reset  (~reset),
      .enable (enable),
      .a      (a_q),
      .b      (b_q),
      .sum    (sum),
      .done   (done)
   );
   // round-robin search from ptr; requester being acked this cycle is masked out
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % N_REQ);
         if (!found && mreq[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end
   // next state and FSM-driven controls
   always_comb begin
      grant   = (state == IDLE) && found;
      enable  = (state == ISSUE);
      finish  = (state == WAIT) && done;
      busy    = (state != IDLE);
      state_n = grant ? ISSUE : enable ? WAIT : finish ? IDLE : state;
   end
   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end
   // operand latch at grant; result, ack and pointer update at completion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         id        <= '0;
         a_q       <= '0;
         b_q       <= '0;
         ack       <= '0;
         result    <= '0;
         result_id <= '0;
      end else begin
         ack <= '0;
         if (grant) begin
            id  <= win;
            a_q <= a_in[{win, 4'b0} +: 16];
            b_q <= b_in[{win, 4'b0} +: 16];
         end
         if (finish) begin
            ack[id]   <= 1'b1;
            result    <= sum;
            result_id <= id;
            ptr       <= (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scoreboard bench for the round-robin adder arbiter
module tb_adder_arbiter;
   localparam int N = 4;
   logic            clk = 1'b0, reset = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*16-1:0] a_in = '0, b_in = '0;
   logic [N-1:0]    ack;
   logic [15:0]     result;
   logic [1:0]      result_id;
   logic            busy;
   int              errors = 0, checks = 0;
   int              qi[$];
   logic [15:0]     qr[$];
   logic [15:0]     last_res = '0;

   always #5 clk = ~clk;

   adder_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .ack       (ack),
      .result    (result),
      .result_id (result_id),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] avg(input logic [15:0] a, input logic [15:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      return 16'(s >>> 1);
   endfunction

   task automatic push(input int i, input logic [15:0] r);
      qi.push_back(i);
      qr.push_back(r);
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
      a_in[16*i +: 16] = a;
      b_in[16*i +: 16] = b;
      push(i, r);
      req[i] = 1'b1;
   endtask

   task automatic expect_ack(input string tag, input int lat);
      int n = 0;
      int id;
      logic [15:0] r;
      do begin
         @(negedge clk);
         n++;
         if (ack == '0 && n < 40) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_hold"}, result, last_res);
         end
      end while (ack == '0 && n < 40);
      chk({tag, "_lat"}, n, lat);
      if (qi.size() == 0) begin
         chk({tag, "_unexpected_ack"}, ack, 0);
         return;
      end
      id = qi.pop_front();
      r  = qr.pop_front();
      chk({tag, "_ack"}, ack, 1 << id);
      chk({tag, "_result"}, result, r);
      chk({tag, "_id"}, result_id, id);
      chk({tag, "_busy_ack"}, busy, 0);
      last_res = r;
   endtask

   initial begin
      logic [15:0] ca[4], cb[4], cr[4];
      ca = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0003};
      cb = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0002};
      cr = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0002};
      repeat (2) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_result", result, 0);
      chk("rst_id", result_id, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;
      @(negedge clk);
      set_op(0, 16'h0100, 16'h0300, 16'h0200);
      expect_ack("single", 4);
      req = '0;
      @(negedge clk);
      chk("idle_ack", ack, 0);
      chk("idle_busy", busy, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         set_op(1, ca[c], cb[c], cr[c]);
         expect_ack($sformatf("corner%0d", c), 4);
         req = '0;
      end
      @(negedge clk);
      reset = 1'b0;
      last_res = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++)
         set_op(i, 16'(16'h1000 * i + 3), 16'(16'h0100 + i), avg(16'(16'h1000 * i + 3), 16'(16'h0100 + i)));
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         expect_ack($sformatf("all%0d", i), 4);
         req[i] = 1'b0;
      end
      @(negedge clk);
      set_op(0, 16'h0010, 16'h0010, 16'h0010);
      set_op(3, 16'hFFF0, 16'hFFF0, 16'hFFF0);
      expect_ack("wrap0", 4);
      req[0] = 1'b0;
      expect_ack("wrap3", 4);
      req = '0;
      @(negedge clk);
      set_op(0, 16'h0040, 16'h0020, 16'h0030);
      set_op(2, 16'hFF00, 16'h0100, 16'h0000);
      push(0, 16'h0030);
      push(2, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         expect_ack($sformatf("fair%0d", i), 4);
         if (i == 3) req = '0;
      end
      @(negedge clk);
      set_op(3, 16'h0010, 16'h0020, 16'h0018);
      @(negedge clk);
      chk("stab_busy", busy, 1);
      req = '0;
      @(negedge clk);
      a_in[48 +: 16] = 16'h7000;
      expect_ack("stab", 2);
      @(negedge clk);
      set_op(1, 16'h0200, 16'h0002, 16'h0101);
      expect_ack("pre", 4);
      req = '0;
      @(negedge clk);
      a_in[48 +: 16] = 16'h1234;
      req[3] = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      req = '0;
      @(negedge clk);
      chk("mid_ack", ack, 0);
      chk("mid_result", result, 0);
      chk("mid_id", result_id, 0);
      chk("mid_busy", busy, 0);
      last_res = '0;
      reset = 1'b1;
      set_op(1, 16'h0008, 16'h0004, 16'h0006);
      set_op(2, 16'hFFFC, 16'hFFFA, 16'hFFFB);
      expect_ack("post1", 4);
      req[1] = 1'b0;
      expect_ack("post2", 4);
      req = '0;
      repeat (6) @(negedge clk);
      chk("end_ack", ack, 0);
      chk("end_q", qi.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that time-shares one `fixed_point_adder` instance among `N_REQ` requesters in the feature-extraction datapath. Each requester presents a pair of signed 16-bit operands with a level request. The arbiter grants one requester at a time, latches its operands, and sequences the adder's enable. It then returns the adder's 16-bit result to that requester with a one-cycle acknowledge tagged by requester index.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester index.
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, `N_REQ`: level request per requester.
- `a_in`, input, `N_REQ*16`: operand A, signed two's complement; requester i occupies bits [16i+15:16i].
- `b_in`, input, `N_REQ*16`: operand B, same packing as `a_in`.
- `ack`, output, `N_REQ`: one-hot, one-cycle pulse; the result for requester i is valid while `ack[i]` is high.
- `result`, output, 16: signed result of the most recent operation; held until the next operation completes.
- `result_id`, output, `ID_W`: index of the requester that owns `result`.
- `busy`, output, 1: high from grant through the cycle before `ack`.

## Operation
- Shared unit: one `fixed_point_adder`.
  - Its `reset` is driven by `~reset`.
  - Its `enable` is driven only by the FSM.
  - Its 17-bit internal sum {A[15],A}+{B[15],B} is taken as bits [16:1], so `result` = floor((A+B)/2). The result cannot overflow.
- Operands are latched at grant. Changes to `a_in`/`b_in` or `req` after grant do not affect the operation in flight.
- Arbitration: round-robin with pointer `ptr`, reset value 0.
  - Search starts at `ptr`, ascending and wrapping modulo `N_REQ`; the first asserted `req` wins.
  - On completion, `ptr` = granted id + 1, wrapping to 0.
  - Any continuously requesting requester is served within `N_REQ` operations.
- Masking: in the cycle where `ack[i]` is high, `req[i]` is ignored by arbitration. A requester must deassert `req` in the cycle after `ack`, or keep it high to request a new operation.
- FSM:
  - IDLE: if any unmasked `req` is high, latch the winner's id, A and B; set `busy`; go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive adder `enable` = 1 for exactly one cycle; go to WAIT.
  - WAIT: when adder `done` = 1, register `result` from the adder `sum` and set `result_id`; pulse `ack[id]`; clear `busy`; update `ptr`; go to IDLE. Otherwise stay in WAIT.
- Reset (`reset` low), at any time including mid-operation:
  - State goes to IDLE; `ptr` = 0.
  - `ack` = 0, `result` = 0, `result_id` = 0, `busy` = 0.
  - The operation in flight is discarded and never acknowledged; the requester must re-request.
- Reset must be held low across at least one `clk` edge so that the synchronous adder clears.

## Timing
- Request-to-ack latency: `req` sampled high in cycle 0 (IDLE) gives ISSUE in cycle 1, WAIT in cycles 2–3, and `ack` high in cycle 4.
- Adder `done` rises two edges after the enable edge. The arbiter never re-enables the adder before `done`.
- Throughput: one operation per 4 cycles under continuous requests. IDLE in the `ack` cycle can grant the next requester, so the next `ack` comes 4 cycles later.
- `busy` is high for cycles 1–3 of each operation and low in the `ack` cycle.
- `result` and `result_id` change only in the cycle `ack` is asserted and are stable otherwise.
- No combinational path from `req`, `a_in` or `b_in` to any output.

## Test plan
- Single request: with `N_REQ`=4, cycle 0 `req`=4'b0001, A=0x0100, B=0x0300 → `ack`=4'b0001 in cycle 4, `result`=0x0200, `result_id`=0, `busy` high in cycles 1–3 only.
- Arithmetic corners, each on requester 1:
  - 0x7FFF+0x7FFF → 0x7FFF
  - 0x8000+0x8000 → 0x8000
  - 0xFFFF+0x0000 → 0xFFFF
  - 0x0003+0x0002 → 0x0002
- Simultaneous requests: `req`=4'b1111 from reset release, each requester holding req until its ack → acks in order 0, 1, 2, 3 in cycles 4, 8, 12, 16. `ptr` then returns to 0.
- Fairness: `req[0]` and `req[2]` held continuously → ack sequence 0, 2, 0, 2, …; no other ids; 4-cycle spacing.
- Operand stability: change `a_in` for requester 3 in cycle 2 after its grant → `result` reflects the operands latched at grant.
- Reset mid-operation: assert `reset` low in WAIT → no `ack`; all outputs 0 next cycle. After release, `req`=4'b0110 → requester 1 is served first (`ptr`=0).
